// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M divide unit: op encodings, FSM state codes and constants.
package rv32m_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_e;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider: one shift/trial-subtract per step, DIV_ITERS steps per operation.
import rv32m_pkg::*;

module div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic            last
);

  logic [5:0]      count;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // The partial remainder stays below the divisor, so 33 bits hold the shifted value exactly.
  assign shifted = {rem, quo[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs};
  assign last    = (count == 6'(DIV_ITERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      dvs   <= '0;
      quo   <= '0;
      rem   <= '0;
    end else if (load) begin
      count <= '0;
      dvs   <= divisor;
      quo   <= dividend;
      rem   <= '0;
    end else if (step) begin
      count <= count + 6'd1;
      quo   <= {quo[XLEN-2:0], ~trial[XLEN]};
      rem   <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    end
  end

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit with start/busy/done handshake and write-back outputs.
// Optional: define DIV_FAST_PATH_EN to finish divide-by-zero and signed overflow in one edge.
import rv32m_pkg::*;

module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wr_en
);

  state_e          state;
  logic            is_rem;
  logic            q_neg;
  logic            r_neg;
  logic [4:0]      rd_q;
  logic            signed_op;
  logic            s1;
  logic            s2;
  logic            load;
  logic            special;
  logic [XLEN-1:0] special_val;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic            last;

  assign signed_op = ~op[0];
  assign s1        = signed_op & data1[XLEN-1];
  assign s2        = signed_op & data2[XLEN-1];

`ifdef DIV_FAST_PATH_EN
  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (data2 == '0) begin
      special     = 1'b1;
      special_val = op[1] ? data1 : ALL_ONES;
    end else if (signed_op && data1 == INT_MIN && data2 == ALL_ONES) begin
      special     = 1'b1;
      special_val = op[1] ? '0 : INT_MIN;
    end
  end
`else
  assign special     = 1'b0;
  assign special_val = '0;
`endif

  assign load = (state == IDLE) && start && !kill && !special;

  div_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     ((state == CALC) && !kill),
    .dividend (cond_neg(data1, s1)),
    .divisor  (cond_neg(data2, s2)),
    .quo      (quo),
    .rem      (rem),
    .last     (last)
  );

  // A zero divisor must leave the all-ones quotient un-negated; overflow needs no guard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      wr_en  <= 1'b0;
      result <= '0;
      rd_out <= '0;
      rd_q   <= '0;
      is_rem <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
      if (kill) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            busy   <= 1'b1;
            is_rem <= op[1];
            rd_q   <= rd_in;
            q_neg  <= (s1 ^ s2) && (data2 != '0);
            r_neg  <= s1;
            if (special) begin
              result <= special_val;
              rd_out <= rd_in;
              done   <= 1'b1;
              wr_en  <= (rd_in != 5'd0);
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
          CALC: if (last) state <= FIX;
          FIX: begin
            result <= is_rem ? cond_neg(rem, r_neg) : cond_neg(quo, q_neg);
            rd_out <= rd_q;
            done   <= 1'b1;
            wr_en  <= (rd_q != 5'd0);
            state  <= DONE;
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
